region_grow_engine: RTL

- Parametrised successor to the fixed-size region-growing core.
- Holds one greyscale image of ROWS x COLS pixels loaded through a write port. On a seeded start it runs a queue-based (BFS) flood from the seed and produces a 1-bit region mask plus a region pixel count.
- Adds runtime threshold, 4/8-connectivity mode, a start/busy/done handshake, queue-overflow reporting and a mask readback port, in place of file I/O.

---
 rtl/region_grow_engine.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/region_grow_engine.sv
// Seeded BFS region grower over a ROWS x COLS greyscale image held in on-chip RAM.
// Produces a 1-bit region mask (readable after completion) and the region pixel count.
module region_grow_engine #(
  parameter int PIX_W  = 8,
  parameter int ROWS   = 273,
  parameter int COLS   = 182,
  parameter int QDEPTH = 1024,
  parameter int AW     = $clog2(ROWS*COLS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [PIX_W-1:0]        wr_data,
  input  logic                    start,
  input  logic [$clog2(ROWS)-1:0] seed_row,
  input  logic [$clog2(COLS)-1:0] seed_col,
  input  logic [PIX_W-1:0]        threshold,
  input  logic                    conn8,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    seed_err,
  output logic [AW:0]             region_count,
  input  logic [AW-1:0]           mask_raddr,
  output logic                    mask_rdata
);
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int RW1  = RW + 1;
  localparam int CW1  = CW + 1;
  localparam int RS   = RW + 2;
  localparam int CS   = CW + 2;
  localparam int AW1  = AW + 1;
  localparam int QAW  = $clog2(QDEPTH);
  localparam int QCW  = QAW + 1;
  localparam int NPIX = ROWS * COLS;

  localparam logic [RW:0]          ROWS_U = RW1'(ROWS);
  localparam logic [CW:0]          COLS_U = CW1'(COLS);
  localparam logic signed [RS-1:0] ROWS_S = RS'(ROWS);
  localparam logic signed [CS-1:0] COLS_S = CS'(COLS);
  localparam logic [AW:0]          NPIX_V = AW1'(NPIX);
  localparam logic [AW-1:0]        LAST_A = AW'(NPIX - 1);
  localparam logic [QAW:0]         QFULL  = QCW'(QDEPTH);

  typedef enum logic [2:0] {IDLE, CLEAR, SEED_RD, SEED_CHK, POP, NB_RD, NB_CHK, FINISH} state_t;
  state_t state, nstate;

  logic [PIX_W-1:0] img_mem  [NPIX];
  logic             mask_mem [NPIX];
  logic [RW+CW-1:0] q_mem    [QDEPTH];

  logic [RW-1:0]    seed_r_q, cur_r, nb_r;
  logic [CW-1:0]    seed_c_q, cur_c, nb_c;
  logic [PIX_W-1:0] thr_q, seed_val, img_rd_p1;
  logic             conn8_q, mask_rd_p1;
  logic [AW-1:0]    clr_addr, seed_addr, nb_addr, rd_addr, rd_idx, mask_wa;
  logic [2:0]       k;
  logic [QAW-1:0]   qhead, qtail;
  logic [QAW:0]     qcount;
  logic [RW+CW-1:0] q_wdata;
  logic signed [RS-1:0] nr_s;
  logic signed [CS-1:0] nc_s;
  logic seed_oob, nb_in, k_last, q_empty, q_full, accept;
  logic mask_we, mask_wd, q_push, q_pop, img_we;

  // Neighbour order N, S, W, E, NW, NE, SW, SE
  function automatic logic signed [1:0] off_dr(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd4, 3'd5: return -2'sd1;
      3'd1, 3'd6, 3'd7: return 2'sd1;
      default:          return 2'sd0;
    endcase
  endfunction

  function automatic logic signed [1:0] off_dc(input logic [2:0] idx);
    case (idx)
      3'd2, 3'd4, 3'd6: return -2'sd1;
      3'd3, 3'd5, 3'd7: return 2'sd1;
      default:          return 2'sd0;
    endcase
  endfunction

  function automatic logic [PIX_W:0] abs_diff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    logic signed [PIX_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[PIX_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  // Signed neighbour coordinates: -1 and the limit both fall out of range
  assign nr_s      = $signed({2'b00, cur_r}) + RS'(off_dr(k));
  assign nc_s      = $signed({2'b00, cur_c}) + CS'(off_dc(k));
  assign nb_in     = !nr_s[RS-1] && (nr_s < ROWS_S) && !nc_s[CS-1] && (nc_s < COLS_S);
  assign nb_r      = nr_s[RW-1:0];
  assign nb_c      = nc_s[CW-1:0];
  assign nb_addr   = addr_of(nb_r, nb_c);
  assign seed_addr = addr_of(seed_r_q, seed_c_q);
  assign seed_oob  = ({1'b0, seed_r_q} >= ROWS_U) || ({1'b0, seed_c_q} >= COLS_U);
  assign k_last    = (k == (conn8_q ? 3'd7 : 3'd3));
  assign q_empty   = (qcount == '0);
  assign q_full    = (qcount == QFULL);
  assign accept    = !mask_rd_p1 && (abs_diff(img_rd_p1, seed_val) <= {1'b0, thr_q});
  assign rd_addr   = (state == SEED_RD) ? seed_addr : nb_addr;
  assign rd_idx    = ({1'b0, rd_addr} < NPIX_V) ? rd_addr : '0;
  assign img_we    = wr_en && !busy && ({1'b0, wr_addr} < NPIX_V);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate  = state;
    busy    = 1'b1;
    done    = 1'b0;
    mask_we = 1'b0;
    mask_wa = nb_addr;
    mask_wd = 1'b1;
    q_push  = 1'b0;
    q_pop   = 1'b0;
    q_wdata = {nb_r, nb_c};
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nstate = CLEAR;
      end
      CLEAR: begin
        mask_we = 1'b1;
        mask_wa = clr_addr;
        mask_wd = 1'b0;
        if (clr_addr == LAST_A) nstate = SEED_RD;
      end
      SEED_RD:  nstate = seed_oob ? FINISH : SEED_CHK;
      SEED_CHK: begin
        mask_we = 1'b1;
        mask_wa = seed_addr;
        q_push  = 1'b1;
        q_wdata = {seed_r_q, seed_c_q};
        nstate  = POP;
      end
      POP: begin
        q_pop  = !q_empty;
        nstate = q_empty ? FINISH : NB_RD;
      end
      NB_RD: nstate = nb_in ? NB_CHK : (k_last ? POP : NB_RD);
      NB_CHK: begin
        mask_we = accept && !q_full;
        q_push  = accept && !q_full;
        nstate  = k_last ? POP : NB_RD;
      end
      FINISH: begin
        busy   = 1'b0;
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow     <= 1'b0;
      seed_err     <= 1'b0;
      region_count <= '0;
      qhead        <= '0;
      qtail        <= '0;
      qcount       <= '0;
    end else begin
      if (state == IDLE && start) begin
        overflow     <= 1'b0;
        seed_err     <= 1'b0;
        region_count <= '0;
      end
      if (state == SEED_RD && seed_oob) seed_err <= 1'b1;
      if (state == SEED_CHK) region_count <= AW1'(1);
      if (state == NB_CHK && accept) begin
        if (q_full) overflow <= 1'b1;
        else        region_count <= region_count + AW1'(1);
      end
      if (q_push) begin
        qtail  <= qtail + QAW'(1);
        qcount <= qcount + QCW'(1);
      end else if (q_pop) begin
        qhead  <= qhead + QAW'(1);
        qcount <= qcount - QCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      seed_r_q <= seed_row;
      seed_c_q <= seed_col;
      thr_q    <= threshold;
      conn8_q  <= conn8;
    end
    clr_addr <= (state == CLEAR) ? clr_addr + AW'(1) : '0;
    if (state == SEED_CHK) seed_val <= img_rd_p1;
    if (q_pop) {cur_r, cur_c} <= q_mem[qhead];
    if (state == POP) k <= 3'd0;
    else if ((state == NB_RD && !nb_in) || state == NB_CHK) k <= k + 3'd1;
    if (q_push) q_mem[qtail] <= q_wdata;
  end

  // RAM read stage: address issued in SEED_RD/NB_RD, data used in SEED_CHK/NB_CHK
  always_ff @(posedge clk) begin
    if (img_we) img_mem[wr_addr] <= wr_data;
    img_rd_p1 <= img_mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (mask_we) mask_mem[mask_wa] <= mask_wd;
    mask_rd_p1 <= mask_mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rstn) mask_rdata <= 1'b0;
    else       mask_rdata <= ({1'b0, mask_raddr} < NPIX_V) ? mask_mem[mask_raddr] : 1'b0;
  end
endmodule
